arp_cam_hash_table: RTL and testbench
=====================================

Name: arp_cam_hash_table

Overview:
- Hashed IPv4-to-MAC lookup table on the ARP-server side of the NTS ARP path: the consumer end of the key-hashing function.
- Stores (IPv4, MAC) pairs in a direct-mapped, synchronous-read table indexed by an XOR-fold of the IPv4 key.
- Answers lookup requests and serves insert/delete update requests over AXI4-Stream-style valid/ready channels.
- Clears itself after every reset.

Parameters:
- ADDR_W, 8, table index width; table depth is 2^ADDR_W entries.
- KEY_W, 32, key width (IPv4 address).
- VAL_W, 48, value width (MAC address).

Ports:
- ap_clk  in  1  single clock; all logic rising-edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- s_lkp_req_tdata  in  KEY_W  lookup key (IPv4).
- s_lkp_req_tvalid  in  1  lookup request valid.
- s_lkp_req_tready  out  1  lookup request accepted.
- m_lkp_rsp_tdata  out  VAL_W+1  [VAL_W]=hit, [VAL_W-1:0]=MAC (zero on miss).
- m_lkp_rsp_tvalid  out  1  lookup response valid.
- m_lkp_rsp_tready  in  1  lookup response consumed.
- s_upd_req_tdata  in  1+KEY_W+VAL_W  [KEY_W+VAL_W]=op (1 insert, 0 delete), [KEY_W+VAL_W-1:VAL_W]=IPv4, [VAL_W-1:0]=MAC.
- s_upd_req_tvalid  in  1  update request valid.
- s_upd_req_tready  out  1  update request accepted.
- m_upd_rsp_tdata  out  KEY_W+2  [KEY_W+1]=success, [KEY_W]=op echo, [KEY_W-1:0]=IPv4 echo.
- m_upd_rsp_tvalid  out  1  update response valid.
- m_upd_rsp_tready  in  1  update response consumed.
- po_init_done  out  1  table cleared and ready for requests.
- po_entry_count  out  ADDR_W+1  number of valid entries.

Behaviour:
- Reset: ap_rst_n is synchronous and active-low. It is sampled on ap_clk and forces state INIT, the address counter to 0, and these outputs low/zero: all tvalid, all tready, all tdata, po_init_done, po_entry_count, last_served.
- Entry format: {valid, key[KEY_W-1:0], mac[VAL_W-1:0]}. Storage is a single-port RAM with 1-cycle synchronous read.
- Index: idx[i] = XOR of key[k] over all k with k mod ADDR_W == i. For ADDR_W=8 this is the XOR of the 4 key bytes.
- FSM states: INIT, IDLE, LKP_CMP, LKP_RSP, UPD_CMP, UPD_RSP.
- INIT:
  - Writes valid=0 to address 0..2^ADDR_W-1, one per cycle (2^ADDR_W cycles).
  - Then sets po_init_done=1 and enters IDLE.
  - All tready are low during INIT.
- IDLE:
  - tready is asserted only in IDLE, combinationally, for the granted channel.
  - Only one request is accepted per transaction.
- Arbitration when both request channels are valid: grant the channel not in last_served. last_served resets to "update", so lookup wins the first tie. With only one channel valid, grant it.
- Lookup timing:
  - Accept at edge N: latch the key and issue the RAM read.
  - N+1, LKP_CMP: hit = entry.valid & (entry.key == latched key).
  - N+2: m_lkp_rsp_tvalid=1 with {hit, hit ? mac : 0}.
- Update timing:
  - Accept at edge N: latch op/key/mac and issue the RAM read.
  - N+1, UPD_CMP: decide the action, perform any RAM write, and adjust po_entry_count.
  - N+2: m_upd_rsp_tvalid=1.
- Insert rules:
  - Slot invalid: write the entry, count+1, success=1.
  - Valid with the same key: overwrite the MAC, count unchanged, success=1.
  - Valid with a different key (collision): no write, success=0. There is no eviction.
- Delete rules:
  - Valid with the same key: write valid=0, count-1, success=1.
  - Otherwise: no write, success=0.
- Response hold: the response is held stable until its tready is high. On that handshake edge the FSM returns to IDLE and last_served is updated. A response is never dropped or overwritten.
- Minimum issue interval is 3 cycles per request; throughput is limited by response backpressure.
- Read-after-write: the update write completes in UPD_CMP, so any request accepted afterwards sees the new contents.
- po_entry_count never exceeds 2^ADDR_W and never underflows; inserts and deletes that change no slot leave it unchanged.
- Reset mid-operation: any pending request or response is discarded, tvalid drops on the reset cycle, and the table re-initialises. po_init_done is low until INIT completes again.

Test Plan:
- Reset, then count cycles to po_init_done -> exactly 256 cycles (ADDR_W=8). A lookup of 0x0A000001 issued before init_done is not accepted until init_done; afterwards it returns hit=0, MAC=0.
- Insert {0x0A000001, 0x001122334455} -> upd rsp success=1, count=1. Lookup 0x0A000001 -> rsp at accept+2 with hit=1, MAC=0x001122334455.
- Collision: insert 0x0B000000 (same index 0x0B) -> success=0, count stays 1. Lookup 0x0B000000 -> hit=0.
- Overwrite 0x0A000001 with MAC 0xAABBCCDDEEFF -> success=1, count=1, lookup returns the new MAC. Delete 0x0A000001 -> success=1, count=0. Delete again -> success=0, count=0.
- Both channels valid continuously -> grants alternate lookup, update, lookup, and so on. Hold m_lkp_rsp_tready low for 5 cycles -> response tdata stable, no further request accepted.
- Assert ap_rst_n=0 for one cycle while in UPD_RSP -> m_upd_rsp_tvalid=0 next cycle, count=0, a full INIT is re-run, and a prior entry looks up as a miss.

Source files
------------

// File: rtl/arp_cam_hash_table.sv
// Hashed IPv4-to-MAC lookup table: direct-mapped, XOR-folded index, single-port
// synchronous-read storage, with lookup and insert/delete channels arbitrated round-robin.
module arp_cam_hash_table #(
  parameter int ADDR_W = 8,
  parameter int KEY_W  = 32,
  parameter int VAL_W  = 48
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [KEY_W-1:0]         s_lkp_req_tdata,
  input  logic                     s_lkp_req_tvalid,
  output logic                     s_lkp_req_tready,
  output logic [VAL_W:0]           m_lkp_rsp_tdata,
  output logic                     m_lkp_rsp_tvalid,
  input  logic                     m_lkp_rsp_tready,
  input  logic [KEY_W+VAL_W:0]     s_upd_req_tdata,
  input  logic                     s_upd_req_tvalid,
  output logic                     s_upd_req_tready,
  output logic [KEY_W+1:0]         m_upd_rsp_tdata,
  output logic                     m_upd_rsp_tvalid,
  input  logic                     m_upd_rsp_tready,
  output logic                     po_init_done,
  output logic [ADDR_W:0]          po_entry_count,
  output logic [2:0]               dbg_state
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRY_W = 1 + KEY_W + VAL_W;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_LKP_CMP = 3'd2,
    S_LKP_RSP = 3'd3,
    S_UPD_CMP = 3'd4,
    S_UPD_RSP = 3'd5
  } state_t;

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // tvalid and tready are both high; a source holds tdata stable while tvalid is
  // high and tready is low, and never withdraws tvalid before the transfer.

  // Bit i of the index is the parity of every key bit k with k mod ADDR_W == i.
  function automatic logic [ADDR_W-1:0] hash_idx(input logic [KEY_W-1:0] key);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      for (int k = i; k < KEY_W; k += ADDR_W) begin
        idx[i] = idx[i] ^ key[k];
      end
    end
    return idx;
  endfunction

  state_t              state;
  logic [ADDR_W-1:0]   addr_cnt;
  logic                last_lkp;
  logic [KEY_W-1:0]    req_key;
  logic [VAL_W-1:0]    req_mac;
  logic                req_op;
  logic [ADDR_W-1:0]   req_idx;

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  rd_data;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [ENTRY_W-1:0]  ram_wdata;

  logic                grant_lkp;
  logic                grant_upd;
  logic                lkp_acc;
  logic                upd_acc;

  logic [KEY_W-1:0]    upd_key_in;
  logic [VAL_W-1:0]    upd_mac_in;
  logic                upd_op_in;

  logic                rd_valid;
  logic [KEY_W-1:0]    rd_key;
  logic [VAL_W-1:0]    rd_mac;
  logic                key_match;

  logic                upd_write;
  logic                upd_success;
  logic [ENTRY_W-1:0]  upd_wdata;
  logic                cnt_inc;
  logic                cnt_dec;

  assign upd_op_in  = s_upd_req_tdata[KEY_W+VAL_W];
  assign upd_key_in = s_upd_req_tdata[KEY_W+VAL_W-1:VAL_W];
  assign upd_mac_in = s_upd_req_tdata[VAL_W-1:0];

  assign rd_valid  = rd_data[ENTRY_W-1];
  assign rd_key    = rd_data[KEY_W+VAL_W-1:VAL_W];
  assign rd_mac    = rd_data[VAL_W-1:0];
  assign key_match = rd_valid && (rd_key == req_key);

  // On a tie the channel that was not served last wins; last_lkp=0 means update.
  assign grant_upd = s_upd_req_tvalid && (!s_lkp_req_tvalid || last_lkp);
  assign grant_lkp = s_lkp_req_tvalid && !grant_upd;

  assign s_lkp_req_tready = (state == S_IDLE) && grant_lkp;
  assign s_upd_req_tready = (state == S_IDLE) && grant_upd;
  assign lkp_acc = s_lkp_req_tready && s_lkp_req_tvalid;
  assign upd_acc = s_upd_req_tready && s_upd_req_tvalid;

  assign dbg_state = state;

  always_comb begin
    upd_write   = 1'b0;
    upd_success = 1'b0;
    upd_wdata   = {1'b1, req_key, req_mac};
    cnt_inc     = 1'b0;
    cnt_dec     = 1'b0;
    if (req_op) begin
      if (!rd_valid) begin
        upd_write   = 1'b1;
        upd_success = 1'b1;
        cnt_inc     = 1'b1;
      end else if (key_match) begin
        upd_write   = 1'b1;
        upd_success = 1'b1;
      end
    end else if (key_match) begin
      upd_write   = 1'b1;
      upd_success = 1'b1;
      upd_wdata   = '0;
      cnt_dec     = 1'b1;
    end
  end

  // The single RAM port is shared: clear sweep in INIT, read on every IDLE
  // cycle for whichever channel holds the grant, write-back in UPD_CMP.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = req_idx;
    ram_wdata = '0;
    case (state)
      S_INIT: begin
        ram_we   = ap_rst_n;
        ram_addr = addr_cnt;
      end
      S_IDLE: begin
        ram_addr = grant_upd ? hash_idx(upd_key_in) : hash_idx(s_lkp_req_tdata);
      end
      S_UPD_CMP: begin
        ram_we    = ap_rst_n && upd_write;
        ram_wdata = upd_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rd_data <= mem[ram_addr];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state            <= S_INIT;
      addr_cnt         <= '0;
      last_lkp         <= 1'b0;
      req_key          <= '0;
      req_mac          <= '0;
      req_op           <= 1'b0;
      req_idx          <= '0;
      m_lkp_rsp_tdata  <= '0;
      m_lkp_rsp_tvalid <= 1'b0;
      m_upd_rsp_tdata  <= '0;
      m_upd_rsp_tvalid <= 1'b0;
      po_init_done     <= 1'b0;
      po_entry_count   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (addr_cnt == '1) begin
            po_init_done <= 1'b1;
            state        <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (lkp_acc) begin
            req_key <= s_lkp_req_tdata;
            req_idx <= hash_idx(s_lkp_req_tdata);
            state   <= S_LKP_CMP;
          end else if (upd_acc) begin
            req_op  <= upd_op_in;
            req_key <= upd_key_in;
            req_mac <= upd_mac_in;
            req_idx <= hash_idx(upd_key_in);
            state   <= S_UPD_CMP;
          end
        end
        S_LKP_CMP: begin
          m_lkp_rsp_tdata  <= {key_match, key_match ? rd_mac : {VAL_W{1'b0}}};
          m_lkp_rsp_tvalid <= 1'b1;
          state            <= S_LKP_RSP;
        end
        S_LKP_RSP: begin
          if (m_lkp_rsp_tready) begin
            m_lkp_rsp_tvalid <= 1'b0;
            last_lkp         <= 1'b1;
            state            <= S_IDLE;
          end
        end
        S_UPD_CMP: begin
          m_upd_rsp_tdata  <= {upd_success, req_op, req_key};
          m_upd_rsp_tvalid <= 1'b1;
          if (cnt_inc && (po_entry_count < (ADDR_W+1)'(DEPTH))) begin
            po_entry_count <= po_entry_count + 1'b1;
          end else if (cnt_dec && (po_entry_count != '0)) begin
            po_entry_count <= po_entry_count - 1'b1;
          end
          state <= S_UPD_RSP;
        end
        S_UPD_RSP: begin
          if (m_upd_rsp_tready) begin
            m_upd_rsp_tvalid <= 1'b0;
            last_lkp         <= 1'b0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_cam_hash_table.sv
// Bench for arp_cam_hash_table: directed vector table, arbitration, backpressure,
// mid-operation reset and a randomised phase checked against a behavioural table model.
module tb_arp_cam_hash_table;

  localparam int ADDR_W = 8;
  localparam int KEY_W  = 32;
  localparam int VAL_W  = 48;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic [KEY_W-1:0]     s_lkp_req_tdata = '0;
  logic                 s_lkp_req_tvalid = 1'b0;
  logic                 s_lkp_req_tready;
  logic [VAL_W:0]       m_lkp_rsp_tdata;
  logic                 m_lkp_rsp_tvalid;
  logic                 m_lkp_rsp_tready = 1'b1;
  logic [KEY_W+VAL_W:0] s_upd_req_tdata = '0;
  logic                 s_upd_req_tvalid = 1'b0;
  logic                 s_upd_req_tready;
  logic [KEY_W+1:0]     m_upd_rsp_tdata;
  logic                 m_upd_rsp_tvalid;
  logic                 m_upd_rsp_tready = 1'b1;
  logic                 po_init_done;
  logic [ADDR_W:0]      po_entry_count;
  logic [2:0]           dbg_state;

  arp_cam_hash_table #(.ADDR_W(ADDR_W), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .s_lkp_req_tdata  (s_lkp_req_tdata),
    .s_lkp_req_tvalid (s_lkp_req_tvalid),
    .s_lkp_req_tready (s_lkp_req_tready),
    .m_lkp_rsp_tdata  (m_lkp_rsp_tdata),
    .m_lkp_rsp_tvalid (m_lkp_rsp_tvalid),
    .m_lkp_rsp_tready (m_lkp_rsp_tready),
    .s_upd_req_tdata  (s_upd_req_tdata),
    .s_upd_req_tvalid (s_upd_req_tvalid),
    .s_upd_req_tready (s_upd_req_tready),
    .m_upd_rsp_tdata  (m_upd_rsp_tdata),
    .m_upd_rsp_tvalid (m_upd_rsp_tvalid),
    .m_upd_rsp_tready (m_upd_rsp_tready),
    .po_init_done     (po_init_done),
    .po_entry_count   (po_entry_count),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [VAL_W:0]          lkp_exp_q[$];
  logic [ADDR_W+KEY_W+2:0] upd_exp_q[$];
  logic [VAL_W:0]          mon_lkp_exp;
  logic [ADDR_W+KEY_W+2:0] mon_upd_exp;
  logic                    last_lkp_tb = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst_n && m_lkp_rsp_tvalid && m_lkp_rsp_tready) begin
      if (lkp_exp_q.size() == 0) check("lkp_rsp_unexpected", 64'd1, 64'd0);
      else begin
        mon_lkp_exp = lkp_exp_q.pop_front();
        check("lkp_rsp", 64'(m_lkp_rsp_tdata), 64'(mon_lkp_exp));
      end
    end
    if (ap_rst_n && m_upd_rsp_tvalid && m_upd_rsp_tready) begin
      if (upd_exp_q.size() == 0) check("upd_rsp_unexpected", 64'd1, 64'd0);
      else begin
        mon_upd_exp = upd_exp_q.pop_front();
        check("upd_rsp_and_count", 64'({po_entry_count, m_upd_rsp_tdata}), 64'(mon_upd_exp));
      end
    end
  end

  // ---------------- behavioural table model ----------------
  logic        mv [256];
  logic [31:0] mk [256];
  logic [47:0] mm [256];
  logic [8:0]  mcnt;

  function automatic logic [7:0] tb_idx(input logic [31:0] k);
    return k[31:24] ^ k[23:16] ^ k[15:8] ^ k[7:0];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) begin
      mv[i] = 1'b0; mk[i] = '0; mm[i] = '0;
    end
    mcnt = '0;
  endfunction

  function automatic logic [48:0] model_lkp(input logic [31:0] k);
    logic [7:0] i;
    i = tb_idx(k);
    if (mv[i] && mk[i] == k) return {1'b1, mm[i]};
    return '0;
  endfunction

  function automatic logic [33:0] model_upd(input logic op, input logic [31:0] k, input logic [47:0] m);
    logic [7:0] i;
    logic ok;
    i = tb_idx(k);
    ok = 1'b0;
    if (op) begin
      if (!mv[i]) begin
        mv[i] = 1'b1; mk[i] = k; mm[i] = m; mcnt = mcnt + 1'b1; ok = 1'b1;
      end else if (mk[i] == k) begin
        mm[i] = m; ok = 1'b1;
      end
    end else if (mv[i] && mk[i] == k) begin
      mv[i] = 1'b0; mcnt = mcnt - 1'b1; ok = 1'b1;
    end
    return {ok, op, k};
  endfunction

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic wait_drain();
    int n;
    n = 0;
    while ((lkp_exp_q.size() != 0 || upd_exp_q.size() != 0) && n < 200) begin
      @(posedge ap_clk); n++;
    end
    if (lkp_exp_q.size() != 0 || upd_exp_q.size() != 0) check("drain_timeout", 64'd1, 64'd0);
    @(negedge ap_clk);
  endtask

  task automatic do_lkp(input logic [31:0] key, input logic [48:0] exp);
    int n;
    int lat;
    s_lkp_req_tdata = key;
    s_lkp_req_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_lkp_req_tready && n < 2000) begin @(negedge ap_clk); n++; end
    if (!s_lkp_req_tready) begin
      check("lkp_accept_timeout", 64'd0, 64'd1);
      s_lkp_req_tvalid = 1'b0;
      return;
    end
    lkp_exp_q.push_back(exp);
    last_lkp_tb = 1'b1;
    @(negedge ap_clk);
    s_lkp_req_tvalid = 1'b0;
    lat = 1;
    while (!m_lkp_rsp_tvalid && lat < 20) begin @(negedge ap_clk); lat++; end
    check("lkp_latency", 64'(lat), 64'd2);
    wait_drain();
  endtask

  task automatic do_upd(input logic op, input logic [31:0] key, input logic [47:0] mac,
                        input logic [33:0] exp_rsp, input logic [8:0] exp_cnt);
    int n;
    int lat;
    s_upd_req_tdata = {op, key, mac};
    s_upd_req_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_upd_req_tready && n < 2000) begin @(negedge ap_clk); n++; end
    if (!s_upd_req_tready) begin
      check("upd_accept_timeout", 64'd0, 64'd1);
      s_upd_req_tvalid = 1'b0;
      return;
    end
    upd_exp_q.push_back({exp_cnt, exp_rsp});
    last_lkp_tb = 1'b0;
    @(negedge ap_clk);
    s_upd_req_tvalid = 1'b0;
    lat = 1;
    while (!m_upd_rsp_tvalid && lat < 20) begin @(negedge ap_clk); lat++; end
    check("upd_latency", 64'(lat), 64'd2);
    wait_drain();
  endtask

  task automatic count_init(output int cycles, output logic early);
    int n;
    n = 0;
    early = 1'b0;
    while (!po_init_done && n < 1000) begin
      @(negedge ap_clk); n++;
      if (!po_init_done && (s_lkp_req_tready || s_upd_req_tready)) early = 1'b1;
    end
    cycles = n;
  endtask

  // Both channels held valid; grants must alternate starting opposite the last served.
  task automatic burst(input int grants);
    logic prev;
    logic g;
    int got;
    int n;
    logic [31:0] lk;
    logic [31:0] uk;
    logic [33:0] r;
    lk = 32'h0A000001;
    uk = 32'h01020304;
    s_lkp_req_tdata  = lk;
    s_upd_req_tdata  = {1'b0, uk, 48'h0};
    s_lkp_req_tvalid = 1'b1;
    s_upd_req_tvalid = 1'b1;
    #1;
    prev = last_lkp_tb;
    got = 0;
    n = 0;
    while (got < grants && n < 500) begin
      if (s_lkp_req_tready || s_upd_req_tready) begin
        g = s_lkp_req_tready;
        check("arb_alternate", 64'(g), 64'(!prev));
        prev = g;
        got++;
        if (g) lkp_exp_q.push_back(model_lkp(lk));
        else begin
          r = model_upd(1'b0, uk, 48'h0);
          upd_exp_q.push_back({mcnt, r});
        end
      end
      @(negedge ap_clk); n++;
    end
    s_lkp_req_tvalid = 1'b0;
    s_upd_req_tvalid = 1'b0;
    last_lkp_tb = prev;
    if (got < grants) check("arb_timeout", 64'(got), 64'(grants));
    wait_drain();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        is_upd;
    logic        op;
    logic [31:0] key;
    logic [47:0] mac;
    logic [48:0] exp_lkp;
    logic [33:0] exp_upd;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t vecs[11];

  localparam logic [31:0] KEY_A = 32'h0A000001;
  localparam logic [31:0] KEY_B = 32'h0B000000;
  localparam logic [31:0] KEY_C = 32'hC0A80101;
  localparam logic [31:0] KEY_D = 32'h0A000002;

  initial begin
    int cycles;
    logic early;
    logic [48:0] captured;
    logic [33:0] r;
    int n;
    logic [1:0] kind;
    logic [31:0] key;
    logic [47:0] mac;

    vecs[0]  = '{1'b1, 1'b1, KEY_A, 48'h001122334455, 49'h0, {1'b1, 1'b1, KEY_A}, 9'd1};
    vecs[1]  = '{1'b0, 1'b0, KEY_A, 48'h0, {1'b1, 48'h001122334455}, 34'h0, 9'd0};
    vecs[2]  = '{1'b1, 1'b1, KEY_B, 48'h0000DEADBEEF, 49'h0, {1'b0, 1'b1, KEY_B}, 9'd1};
    vecs[3]  = '{1'b0, 1'b0, KEY_B, 48'h0, 49'h0, 34'h0, 9'd0};
    vecs[4]  = '{1'b1, 1'b1, KEY_A, 48'hAABBCCDDEEFF, 49'h0, {1'b1, 1'b1, KEY_A}, 9'd1};
    vecs[5]  = '{1'b0, 1'b0, KEY_A, 48'h0, {1'b1, 48'hAABBCCDDEEFF}, 34'h0, 9'd0};
    vecs[6]  = '{1'b1, 1'b0, KEY_A, 48'h0, 49'h0, {1'b1, 1'b0, KEY_A}, 9'd0};
    vecs[7]  = '{1'b1, 1'b0, KEY_A, 48'h0, 49'h0, {1'b0, 1'b0, KEY_A}, 9'd0};
    vecs[8]  = '{1'b0, 1'b0, KEY_A, 48'h0, 49'h0, 34'h0, 9'd0};
    vecs[9]  = '{1'b1, 1'b1, KEY_C, 48'h0A0B0C0D0E0F, 49'h0, {1'b1, 1'b1, KEY_C}, 9'd1};
    vecs[10] = '{1'b0, 1'b0, KEY_C, 48'h0, {1'b1, 48'h0A0B0C0D0E0F}, 34'h0, 9'd0};

    model_clear();

    // Reset state, with a lookup already pending before init completes.
    s_lkp_req_tdata  = KEY_A;
    s_lkp_req_tvalid = 1'b1;
    repeat (4) @(negedge ap_clk);
    check("rst_ctrl", 64'({s_lkp_req_tready, s_upd_req_tready, m_lkp_rsp_tvalid,
                          m_upd_rsp_tvalid, po_init_done}), 64'd0);
    check("rst_lkp_tdata", 64'(m_lkp_rsp_tdata), 64'd0);
    check("rst_upd_tdata", 64'(m_upd_rsp_tdata), 64'd0);
    check("rst_count", 64'(po_entry_count), 64'd0);
    ap_rst_n = 1'b1;
    count_init(cycles, early);
    check("init_cycles", 64'(cycles), 64'd256);
    check("no_accept_before_init", 64'(early), 64'd0);
    do_lkp(KEY_A, 49'h0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_upd) begin
        r = model_upd(vecs[i].op, vecs[i].key, vecs[i].mac);
        do_upd(vecs[i].op, vecs[i].key, vecs[i].mac, vecs[i].exp_upd, vecs[i].exp_cnt);
      end else begin
        do_lkp(vecs[i].key, vecs[i].exp_lkp);
      end
    end

    burst(6);

    // Lookup response held under backpressure while an update waits.
    m_lkp_rsp_tready = 1'b0;
    s_lkp_req_tdata  = KEY_C;
    s_lkp_req_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_lkp_req_tready && n < 100) begin @(negedge ap_clk); n++; end
    check("bp_accept", 64'(s_lkp_req_tready), 64'd1);
    lkp_exp_q.push_back(model_lkp(KEY_C));
    last_lkp_tb = 1'b1;
    @(negedge ap_clk);
    s_lkp_req_tvalid = 1'b0;
    s_upd_req_tdata  = {1'b0, 32'h01020304, 48'h0};
    s_upd_req_tvalid = 1'b1;
    n = 0;
    while (!m_lkp_rsp_tvalid && n < 20) begin @(negedge ap_clk); n++; end
    captured = m_lkp_rsp_tdata;
    check("bp_rsp_value", 64'(captured), 64'({1'b1, 48'h0A0B0C0D0E0F}));
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("bp_hold", 64'({m_lkp_rsp_tvalid, m_lkp_rsp_tdata, s_lkp_req_tready, s_upd_req_tready}),
            64'({1'b1, captured, 2'b00}));
    end
    @(posedge ap_clk);
    #1 m_lkp_rsp_tready = 1'b1;
    wait_drain();
    r = model_upd(1'b0, 32'h01020304, 48'h0);
    do_upd(1'b0, 32'h01020304, 48'h0, r, mcnt);

    // Randomised mix over colliding key sets.
    for (int i = 0; i < 40; i++) begin
      kind = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) key = {8'h0A, 16'h0, 8'($urandom_range(0, 7))};
      else                           key = {8'h0B, 16'h0, 8'($urandom_range(0, 7))};
      mac = {$urandom, 16'($urandom)};
      if (kind == 2'd0) do_lkp(key, model_lkp(key));
      else begin
        r = model_upd(kind == 2'd1, key, mac);
        do_upd(kind == 2'd1, key, mac, r, mcnt);
      end
    end

    // Reset while an update response is stalled.
    m_upd_rsp_tready = 1'b0;
    s_upd_req_tdata  = {1'b1, KEY_D, 48'h111111111111};
    s_upd_req_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_upd_req_tready && n < 100) begin @(negedge ap_clk); n++; end
    @(negedge ap_clk);
    s_upd_req_tvalid = 1'b0;
    n = 0;
    while (!m_upd_rsp_tvalid && n < 20) begin @(negedge ap_clk); n++; end
    check("rst_mid_pending", 64'(m_upd_rsp_tvalid), 64'd1);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("rst_mid_tvalid", 64'(m_upd_rsp_tvalid), 64'd0);
    check("rst_mid_count", 64'(po_entry_count), 64'd0);
    check("rst_mid_init_done", 64'(po_init_done), 64'd0);
    ap_rst_n = 1'b1;
    lkp_exp_q.delete();
    upd_exp_q.delete();
    model_clear();
    last_lkp_tb = 1'b0;
    m_upd_rsp_tready = 1'b1;
    count_init(cycles, early);
    check("reinit_cycles", 64'(cycles), 64'd256);
    burst(2);
    do_lkp(KEY_D, 49'h0);

    repeat (5) @(negedge ap_clk);
    check("queues_empty", 64'(lkp_exp_q.size() + upd_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
